// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter that sequences single-word accesses to DataMemory.
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   pN_req/pN_rw/pN_addr/pN_wdata (N=0,1) request held until pN_ack; rw=1 write
//   pN_ack/pN_err/pN_rdata               one-cycle completion pulse, error flag, read data
//   mem_valid/mem_rw/mem_addr/mem_wr_data DataMemory request
//   mem_rd_data/mem_ready                DataMemory response
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 4112,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state_q;
    logic        last_q;
    logic        win_q;
    logic        bad_q;
    logic [7:0]  timer_q;
    logic        win_d;
    logic        sel_rw_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic        rsp_d;
    logic        rsp_err_d;
    logic [31:0] rsp_data_d;

    always_comb begin
        // Contention goes to the port that did not win last time.
        win_d       = (p0_req && p1_req) ? ~last_q : p1_req;
        sel_rw_d    = win_d ? p1_rw : p0_rw;
        sel_addr_d  = win_d ? p1_addr : p0_addr;
        sel_wdata_d = win_d ? p1_wdata : p0_wdata;
        // A rejected address spends its ISSUE slot idle, so its error lands one cycle before a real access would.
        rsp_d       = (state_q == ISSUE && bad_q) ||
                      (state_q == WAIT && (mem_ready || timer_q == 8'(TIMEOUT - 1)));
        rsp_err_d   = state_q == ISSUE || !mem_ready;
        rsp_data_d  = (state_q == WAIT && mem_ready && !mem_rw) ? mem_rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            bad_q       <= 1'b0;
            timer_q     <= '0;
            p0_ack      <= 1'b0;
            p0_err      <= 1'b0;
            p0_rdata    <= '0;
            p1_ack      <= 1'b0;
            p1_err      <= 1'b0;
            p1_rdata    <= '0;
            mem_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            p0_ack    <= rsp_d && !win_q;
            p1_ack    <= rsp_d && win_q;
            p0_err    <= rsp_d && !win_q && rsp_err_d;
            p1_err    <= rsp_d && win_q && rsp_err_d;
            p0_rdata  <= win_q ? '0 : rsp_data_d;
            p1_rdata  <= win_q ? rsp_data_d : '0;
            mem_valid <= 1'b0;
            case (state_q)
                IDLE: if (p0_req || p1_req) begin
                    win_q       <= win_d;
                    last_q      <= win_d;
                    mem_rw      <= sel_rw_d;
                    mem_addr    <= sel_addr_d;
                    mem_wr_data <= sel_wdata_d;
                    bad_q       <= sel_addr_d >= ADDR_LIMIT;
                    mem_valid   <= sel_addr_d < ADDR_LIMIT;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= bad_q ? RESP : WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (rsp_d) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
